// File: rtl/instr_dispatch_ctrl.sv
// Dispatches decoded instructions to per-opcode FSMs and arbitrates the shared data bus.
// Optional WAIT-state watchdog is compiled in when DISPATCH_TIMEOUT_EN is defined.
module instr_dispatch_ctrl #(
  parameter int NUM_FSM     = 4,
  parameter int OPCODE_W    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic [5:0]          instr_source,
  input  logic [5:0]          instr_dest,
  output logic [NUM_FSM-1:0]  fsm_start,
  input  logic [NUM_FSM-1:0]  fsm_done,
  output logic [5:0]          fsm_source,
  output logic [5:0]          fsm_dest,
  output logic [NUM_FSM-1:0]  bus_grant,
  output logic                busy,
  output logic                illegal_op,
  output logic                timeout_err
);

  localparam int IDX_W = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RETIRE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [5:0]         r_source;
  logic [5:0]         r_dest;
  logic               r_illegal;
  logic               w_accept;
  logic               w_legal;
  logic [NUM_FSM-1:0] w_onehot;

  assign w_accept = instr_valid && (r_state == S_IDLE);
  assign w_legal  = {1'b0, instr_opcode} < (OPCODE_W + 1)'(NUM_FSM);
  assign w_onehot = NUM_FSM'(1) << r_idx;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_expire;
`endif

  always_comb begin
    w_next = r_state;
`ifdef DISPATCH_TIMEOUT_EN
    w_expire = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (w_accept && w_legal) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (fsm_done[r_idx]) begin
          w_next = S_RETIRE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        // Done in the expiry cycle wins, so the watchdog only fires without it.
        else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_expire = 1'b1;
          w_next   = S_RETIRE;
        end
`endif
      end
      S_RETIRE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_source  <= '0;
      r_dest    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        r_idx    <= instr_opcode[IDX_W-1:0];
        r_source <= instr_source;
        r_dest   <= instr_dest;
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  // Counter restarts in LAUNCH so the first WAIT cycle sees zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (r_state == S_LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign timeout_err = r_timeout;
`else
  assign timeout_err = 1'b0;
`endif

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign fsm_start   = (r_state == S_LAUNCH) ? w_onehot : '0;
  assign bus_grant   = ((r_state == S_LAUNCH) || (r_state == S_WAIT)) ? w_onehot : '0;
  assign fsm_source  = r_source;
  assign fsm_dest    = r_dest;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Directed, table-driven bench for instr_dispatch_ctrl with hand-written timeout sequences.
module tb_instr_dispatch_ctrl;

  logic       clock;
  logic       reset;
  logic       instrValid;
  logic       instrReady;
  logic [3:0] instrOpcode;
  logic [5:0] instrSource;
  logic [5:0] instrDest;
  logic [3:0] fsmStart;
  logic [3:0] fsmDone;
  logic [5:0] fsmSource;
  logic [5:0] fsmDest;
  logic [3:0] busGrant;
  logic       busy;
  logic       illegalOp;
  logic       timeoutErr;

  int checkCount = 0;
  int failCount  = 0;

  instr_dispatch_ctrl #(
    .NUM_FSM    (4),
    .OPCODE_W   (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instrValid),
    .instr_ready (instrReady),
    .instr_opcode(instrOpcode),
    .instr_source(instrSource),
    .instr_dest  (instrDest),
    .fsm_start   (fsmStart),
    .fsm_done    (fsmDone),
    .fsm_source  (fsmSource),
    .fsm_dest    (fsmDest),
    .bus_grant   (busGrant),
    .busy        (busy),
    .illegal_op  (illegalOp),
    .timeout_err (timeoutErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [3:0] op;
    logic [5:0] src;
    logic [5:0] dst;
    logic [3:0] done;
    logic       eReady;
    logic [3:0] eStart;
    logic [3:0] eGrant;
    logic [5:0] eSrc;
    logic [5:0] eDst;
    logic       eBusy;
    logic       eIll;
  } vec_t;

  vec_t vecs[23];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle before sampling.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [3:0] op,
                               input logic [5:0] src, input logic [5:0] dst, input logic [3:0] done);
    reset       = rst;
    instrValid  = valid;
    instrOpcode = op;
    instrSource = src;
    instrDest   = dst;
    fsmDone     = done;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instrValid  = 1'b0;
    instrOpcode = '0;
    instrSource = '0;
    instrDest   = '0;
    fsmDone     = '0;

    // rst valid op src dst done | ready start grant src dst busy ill
    vecs[0]  = '{1'b1, 1'b1, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd0,  6'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd0,  6'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd0,  6'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd1, 6'd3,  6'd2,  4'b0000, 1'b0, 4'b0010, 4'b0010, 6'd3,  6'd2,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b0, 4'b0000, 4'b0010, 6'd3,  6'd2,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b0, 4'b0000, 4'b0010, 6'd3,  6'd2,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0010, 1'b0, 4'b0000, 4'b0000, 6'd3,  6'd2,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd3,  6'd2,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd9, 6'd5,  6'd7,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd5,  6'd7,  1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'd0, 6'd10, 6'd11, 4'b0000, 1'b0, 4'b0001, 4'b0001, 6'd10, 6'd11, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd2, 6'd20, 6'd21, 4'b1000, 1'b0, 4'b0000, 4'b0001, 6'd10, 6'd11, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'd2, 6'd20, 6'd21, 4'b1000, 1'b0, 4'b0000, 4'b0001, 6'd10, 6'd11, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd2, 6'd20, 6'd21, 4'b0100, 1'b0, 4'b0000, 4'b0001, 6'd10, 6'd11, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'd2, 6'd20, 6'd21, 4'b0001, 1'b0, 4'b0000, 4'b0000, 6'd10, 6'd11, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'd2, 6'd20, 6'd21, 4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd10, 6'd11, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'd2, 6'd20, 6'd21, 4'b0000, 1'b0, 4'b0100, 4'b0100, 6'd20, 6'd21, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b0, 4'b0000, 4'b0100, 6'd20, 6'd21, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b1000, 1'b0, 4'b0000, 4'b0100, 6'd20, 6'd21, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd0,  6'd0,  1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'd3, 6'd33, 6'd44, 4'b0000, 1'b0, 4'b1000, 4'b1000, 6'd33, 6'd44, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b1000, 1'b0, 4'b0000, 4'b1000, 6'd33, 6'd44, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b1000, 1'b0, 4'b0000, 4'b0000, 6'd33, 6'd44, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 4'd0, 6'd0,  6'd0,  4'b0000, 1'b1, 4'b0000, 4'b0000, 6'd33, 6'd44, 1'b0, 1'b0};

    @(negedge clock);
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].done);
      checkOutput($sformatf("v%0d.ready", i), {7'd0, instrReady}, {7'd0, vecs[i].eReady});
      checkOutput($sformatf("v%0d.start", i), {4'd0, fsmStart}, {4'd0, vecs[i].eStart});
      checkOutput($sformatf("v%0d.grant", i), {4'd0, busGrant}, {4'd0, vecs[i].eGrant});
      checkOutput($sformatf("v%0d.grantOnehot", i), {7'd0, $onehot0(busGrant)}, 8'd1);
      checkOutput($sformatf("v%0d.source", i), {2'd0, fsmSource}, {2'd0, vecs[i].eSrc});
      checkOutput($sformatf("v%0d.dest", i), {2'd0, fsmDest}, {2'd0, vecs[i].eDst});
      checkOutput($sformatf("v%0d.busy", i), {7'd0, busy}, {7'd0, vecs[i].eBusy});
      checkOutput($sformatf("v%0d.illegal", i), {7'd0, illegalOp}, {7'd0, vecs[i].eIll});
      checkOutput($sformatf("v%0d.timeout", i), {7'd0, timeoutErr}, 8'd0);
    end

    // Launch FSM 1 and never answer with done.
    applyStimulus(1'b0, 1'b1, 4'd1, 6'd1, 6'd1, 4'b0000);
    checkOutput("wd.start", {4'd0, fsmStart}, 8'b0000_0010);
    instrValid = 1'b0;

`ifdef DISPATCH_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
      checkOutput($sformatf("wd.wait%0d.grant", i), {4'd0, busGrant}, 8'b0000_0010);
      checkOutput($sformatf("wd.wait%0d.timeout", i), {7'd0, timeoutErr}, 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
    checkOutput("wd.expire.timeout", {7'd0, timeoutErr}, 8'd1);
    checkOutput("wd.expire.grant", {4'd0, busGrant}, 8'd0);
    checkOutput("wd.expire.busy", {7'd0, busy}, 8'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
    checkOutput("wd.idle.timeout", {7'd0, timeoutErr}, 8'd0);
    checkOutput("wd.idle.ready", {7'd0, instrReady}, 8'd1);

    // Done arriving in the expiry cycle must retire normally.
    applyStimulus(1'b0, 1'b1, 4'd1, 6'd1, 6'd1, 4'b0000);
    instrValid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
    end
    checkOutput("prio.stillWait", {4'd0, busGrant}, 8'b0000_0010);
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0010);
    checkOutput("prio.timeout", {7'd0, timeoutErr}, 8'd0);
    checkOutput("prio.grant", {4'd0, busGrant}, 8'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
    checkOutput("prio.ready", {7'd0, instrReady}, 8'd1);
    checkOutput("prio.timeoutAfter", {7'd0, timeoutErr}, 8'd0);
`else
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
      checkOutput($sformatf("hold%0d.grant", i), {4'd0, busGrant}, 8'b0000_0010);
    end
    checkOutput("hold.busy", {7'd0, busy}, 8'd1);
    checkOutput("hold.timeout", {7'd0, timeoutErr}, 8'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0010);
    checkOutput("hold.retireGrant", {4'd0, busGrant}, 8'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 4'b0000);
    checkOutput("hold.ready", {7'd0, instrReady}, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
